// File: rtl/dsp48e2_lite.sv
// dsp48e2_lite: reduced DSP48E2-style 48-bit slice with W/X/Y/Z muxes, SIMD ALU, 27x18 multiplier and optional A/B/C/P registers
module dsp48e2_lite #(
  parameter string       USE_SIMD = "ONE48",
  parameter string       USE_MULT = "NONE",
  parameter int          AREG     = 0,
  parameter int          BREG     = 0,
  parameter int          CREG     = 0,
  parameter int          PREG     = 0,
  parameter logic [47:0] RND      = 48'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [8:0]  opmode,
  input  logic [3:0]  alumode,
  output logic [47:0] p,
  output logic [3:0]  carryout
);
  // Per 12-bit segment: does a lane start here, and does a lane end here (and so own a carryout bit)
  localparam logic [3:0] ST = (USE_SIMD == "FOUR12") ? 4'b1111 : (USE_SIMD == "TWO24") ? 4'b0101 : 4'b0001;
  localparam logic [3:0] EN = (USE_SIMD == "FOUR12") ? 4'b1111 : (USE_SIMD == "TWO24") ? 4'b1010 : 4'b1000;
  localparam bit MULT = (USE_MULT == "MULTIPLY");
  logic [29:0] a_r, aq;
  logic [17:0] b_r, bq;
  logic [47:0] c_r, cq, p_r, alu_p, ab, m, pfb, shr, x, y, z, w;
  logic [3:0]  co_r, alu_co;
  logic signed [44:0] prod;
  logic [51:0] r;
  logic [2:0]  k0, kn;
  logic        sub, neg;
  // Four-operand segmented adder: carries ripple between 12-bit segments except at lane starts,
  // where k0 (lane 0) or kn (other lanes) is injected instead. Top nibble holds lane carryouts.
  function automatic logic [51:0] ladd(input logic [47:0] o0, o1, o2, o3, input logic [2:0] k0_i, kn_i);
    logic [14:0] s;
    logic [2:0]  cy;
    ladd = '0;
    cy = '0;
    for (int i = 0; i < 4; i++) begin
      cy = (i == 0) ? k0_i : ST[i] ? kn_i : cy;
      s = 15'(o0[12*i +: 12]) + 15'(o1[12*i +: 12]) + 15'(o2[12*i +: 12]) + 15'(o3[12*i +: 12]) + 15'(cy);
      ladd[12*i +: 12] = s[11:0];
      ladd[48+i] = EN[i] & s[12];
      cy = s[14:12];
    end
  endfunction
  assign aq   = (AREG != 0) ? a_r : a;
  assign bq   = (BREG != 0) ? b_r : b;
  assign cq   = (CREG != 0) ? c_r : c;
  assign ab   = {aq, bq};
  assign prod = $signed(aq[26:0]) * $signed(bq);
  assign m    = MULT ? {{3{prod[44]}}, prod} : '0;
  assign pfb  = (PREG != 0) ? p_r : '0;
  assign shr  = $signed(pfb) >>> 17;
  // Operand muxes and ALU; subtract uses -(W+X+Y+CIN) = ~W+~X+~Y+3-CIN per lane, and -Z-1 = ~Z
  always_comb begin
    x = (opmode[1:0] == 2'b01) ? m : (opmode[1:0] == 2'b10) ? pfb : (opmode[1:0] == 2'b11) ? ab : '0;
    y = (opmode[3:2] == 2'b10) ? '1 : (opmode[3:2] == 2'b11) ? cq : '0;
    z = (opmode[6:4] == 3'b010 || opmode[6:4] == 3'b100) ? pfb : (opmode[6:4] == 3'b011) ? cq :
        (opmode[6:4] == 3'b110) ? shr : '0;
    w = (opmode[8:7] == 2'b01) ? pfb : (opmode[8:7] == 2'b10) ? RND : (opmode[8:7] == 2'b11) ? cq : '0;
    sub = (alumode == 4'b0011);
    neg = (alumode == 4'b0001);
    k0 = sub ? 3'd3 - {2'b0, carryin} : {2'b0, carryin};
    kn = sub ? 3'd3 : 3'd0;
    r = ladd(neg ? ~z : z, sub ? ~w : w, sub ? ~x : x, sub ? ~y : y, k0, kn);
    alu_p = (alumode == 4'b0000 || sub || neg) ? r[47:0] : (alumode == 4'b0010) ? ~r[47:0] :
            (alumode == 4'b0100) ? x ^ z : (alumode == 4'b1100) ? x & z : '0;
    alu_co = (alumode == 4'b0000) ? r[51:48] : '0;
  end
  // Pipeline registers: reset clears, ce loads, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      p_r  <= '0;
      co_r <= '0;
    end else if (ce) begin
      a_r  <= a;
      b_r  <= b;
      c_r  <= c;
      p_r  <= alu_p;
      co_r <= alu_co;
    end
  end
  assign p        = (PREG != 0) ? p_r : alu_p;
  assign carryout = (PREG != 0) ? co_r : alu_co;
endmodule

// File: tb/tb_dsp48e2_lite.sv
// tb_dsp48e2_lite: randomized self-checking bench against a lane-arithmetic reference model
module tb_dsp48e2_lite;
  logic        clock, reset, ce, carryin;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [8:0]  opmode;
  logic [3:0]  alumode;
  logic [47:0] p_four, p_two, p_one, p_mul, p_acc;
  logic [3:0]  co_four, co_two, co_one, co_mul, co_acc;
  int errors, checks;
  logic [47:0] acc;
  logic [47:0] mq[$];
  logic [51:0] e4, e2, e1;
  logic [3:0]  alus[7];

  dsp48e2_lite #(.USE_SIMD("FOUR12")) u_four (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p_four), .carryout(co_four));
  dsp48e2_lite #(.USE_SIMD("TWO24")) u_two (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p_two), .carryout(co_two));
  dsp48e2_lite #(.USE_SIMD("ONE48")) u_one (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p_one), .carryout(co_one));
  dsp48e2_lite #(.USE_MULT("MULTIPLY"), .AREG(1), .BREG(1), .PREG(1)) u_mul (.clock(clock), .reset(reset),
    .ce(ce), .a(a), .b(b), .c(c), .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p_mul),
    .carryout(co_mul));
  dsp48e2_lite #(.PREG(1)) u_acc (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p_acc), .carryout(co_acc));

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ab(input logic [47:0] v);
    {a, b} = v;
  endtask

  // Reference for combinational slices with no multiplier, no P feedback and RND=0
  function automatic logic [51:0] ref_comb(int lw, logic [47:0] abv, logic [47:0] cv, logic cin,
                                           logic [8:0] op, logic [3:0] alu);
    logic [47:0] x, y, z, w, pr;
    logic [3:0]  co;
    longint unsigned msk, xl, yl, zl, wl, s, sum, r;
    x = (op[1:0] == 2'b11) ? abv : '0;
    y = (op[3:2] == 2'b10) ? '1 : (op[3:2] == 2'b11) ? cv : '0;
    z = (op[6:4] == 3'b011) ? cv : '0;
    w = (op[8:7] == 2'b11) ? cv : '0;
    pr = '0;
    co = '0;
    msk = (64'd1 << lw) - 1;
    for (int l = 0; l < 48 / lw; l++) begin
      xl = (64'(x) >> (l * lw)) & msk;
      yl = (64'(y) >> (l * lw)) & msk;
      zl = (64'(z) >> (l * lw)) & msk;
      wl = (64'(w) >> (l * lw)) & msk;
      s = wl + xl + yl + ((l == 0) ? 64'(cin) : 64'd0);
      sum = zl + s;
      case (alu)
        4'b0000: r = sum;
        4'b0011: r = zl - s;
        4'b0001: r = s - zl - 1;
        4'b0010: r = ~sum;
        default: r = 0;
      endcase
      pr = pr | 48'((r & msk) << (l * lw));
      if (alu == 4'b0000) co[(lw == 12) ? l : (lw == 24) ? 2 * l + 1 : 3] = 1'((sum >> lw) & 1);
    end
    if (alu == 4'b0100) pr = x ^ z;
    if (alu == 4'b1100) pr = x & z;
    return {co, pr};
  endfunction

  function automatic logic [47:0] mexp(logic [29:0] av, logic [17:0] bv);
    longint pa, pb;
    pa = longint'($signed(av[26:0]));
    pb = longint'($signed(bv));
    return 48'(pa * pb);
  endfunction

  task automatic acc_step(input logic rs, input logic en, input string tag);
    reset = rs;
    ce = en;
    @(posedge clock);
    #1;
    if (rs) acc = '0;
    else if (en) acc = acc + 48'd1;
    chk(tag, p_acc, acc);
    chk({tag, "_co"}, 48'(co_acc), 48'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    alus = '{4'b0000, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b0111};
    reset = 1; ce = 0; carryin = 0; a = '0; b = '0; c = '0; opmode = '0; alumode = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mul_p", p_mul, 48'h0);
    chk("rst_acc_p", p_acc, 48'h0);
    chk("rst_acc_co", 48'(co_acc), 48'h0);

    set_ab(48'h800001001001); c = 48'h800FFF001123; opmode = 9'b000110011; alumode = 4'b0000;
    #1;
    chk("four_add_p", p_four, 48'h000000002124);
    chk("four_add_co", 48'(co_four), 48'hC);
    chk("one_add_p", p_one, 48'h001000002124);
    chk("one_add_co", 48'(co_one), 48'h8);
    set_ab(48'h000001000007); c = 48'h000010000005; alumode = 4'b0011;
    #1;
    chk("two_sub_p", p_two, 48'h00000FFFFFFE);
    chk("two_sub_co", 48'(co_two), 48'h0);
    set_ab(48'h0F0F0F0F0F0F); c = 48'hFFFF0000FFFF; alumode = 4'b0100;
    #1;
    chk("xor_p", p_four, 48'hF0F00F0FF0F0);
    chk("xor_co", 48'(co_four), 48'h0);

    for (int t = 0; t < 80; t++) begin
      set_ab({$urandom, $urandom});
      c = {$urandom, $urandom};
      carryin = 1'($urandom);
      opmode = 9'($urandom);
      alumode = ($urandom_range(0, 7) == 7) ? 4'($urandom) : alus[$urandom_range(0, 6)];
      #1;
      e4 = ref_comb(12, {a, b}, c, carryin, opmode, alumode);
      e2 = ref_comb(24, {a, b}, c, carryin, opmode, alumode);
      e1 = ref_comb(48, {a, b}, c, carryin, opmode, alumode);
      chk("rnd_four_p", p_four, e4[47:0]);
      chk("rnd_four_co", 48'(co_four), 48'(e4[51:48]));
      chk("rnd_two_p", p_two, e2[47:0]);
      chk("rnd_two_co", 48'(co_two), 48'(e2[51:48]));
      chk("rnd_one_p", p_one, e1[47:0]);
      chk("rnd_one_co", 48'(co_one), 48'(e1[51:48]));
    end

    opmode = 9'b000000101; alumode = 4'b0000; carryin = 0; c = '0;
    a = 30'h07FFFFFD; b = 18'd5; ce = 1; reset = 0;
    @(posedge clock);
    #1;
    chk("mul_lat1", p_mul, 48'h0);
    @(posedge clock);
    #1;
    chk("mul_lat2", p_mul, 48'hFFFFFFFFFFF1);
    mq.push_back(mexp(a, b));
    for (int t = 0; t < 30; t++) begin
      a = $urandom;
      b = 18'($urandom);
      mq.push_back(mexp(a, b));
      @(posedge clock);
      #1;
      chk("mul_rnd", p_mul, mq.pop_front());
    end

    opmode = 9'b000100011; alumode = 4'b0000; a = '0; b = 18'd1; c = '0; carryin = 0;
    acc = '0;
    acc_step(1, 1, "acc_rst");
    for (int t = 0; t < 3; t++) acc_step(0, 1, "acc_inc");
    acc_step(0, 0, "acc_hold");
    acc_step(0, 0, "acc_hold");
    acc_step(1, 1, "acc_mid_rst");
    acc_step(0, 1, "acc_restart");
    acc_step(0, 1, "acc_restart");
    for (int t = 0; t < 40; t++) acc_step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, "acc_rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
